hazard_unit_p: RTL and testbench
================================

Name: hazard_unit_p

Overview:
Parameterised hazard controller for the 5-stage pipelined RV32I core. It replaces the load-use-only stall logic with a complete hazard block:
- EX-stage operand forwarding selects
- load-use stall lasting a configurable number of bubbles
- branch/jump flush
- whole-pipeline freeze while data memory is busy

It sits beside the pipeline registers and drives their enables and flushes.

Parameters:
ADDR_W, 5, register address width
LU_BUBBLES, 1, bubbles inserted per load-use hazard (legal 1..3; covers deeper memory pipelines)
PERF_W, 32, width of the performance counters (used only with the optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
rs1_d  in  ADDR_W  source register 1 of the instruction in D
rs2_d  in  ADDR_W  source register 2 of the instruction in D
use_rs2_d  in  1  instruction in D reads rs2 (R/S/B types)
rs1_e  in  ADDR_W  source register 1 in E
rs2_e  in  ADDR_W  source register 2 in E
rd_e  in  ADDR_W  destination register in E
load_e  in  1  instruction in E is a load (opcode 7'd3)
pcsrc_e  in  1  taken branch/jump resolved in E
rd_m  in  ADDR_W  destination register in M
regwrite_m  in  1  M writes the register file
rd_w  in  ADDR_W  destination register in W
regwrite_w  in  1  W writes the register file
mem_busy  in  1  data memory not ready; freeze the pipeline
pc_en  out  1  PC register enable
fd_en  out  1  F/D register enable
de_en  out  1  D/E register enable
em_en  out  1  E/M and M/W register enable
flush_d  out  1  clear F/D to NOP
flush_e  out  1  clear D/E to NOP
fwd_a_e  out  2  SrcA select: 00 register file, 01 from W, 10 from M
fwd_b_e  out  2  SrcB select, same encoding
perf_stall  out  PERF_W  load-use bubble count
perf_flush  out  PERF_W  branch flush count
perf_freeze  out  PERF_W  mem_busy freeze cycle count

Behaviour:
- Reset (rst_n low, asynchronous):
  - state RUN, bubble counter 0
  - pc_en = fd_en = de_en = em_en = 0; flush_d = flush_e = 1; fwd_a_e = fwd_b_e = 00
  - Normal operation starts on the first clk edge after release.
- Register x0 never causes a hazard: any comparison against address 0 is false.
- Forwarding (combinational, active in every state):
  - fwd_a_e = 10 if regwrite_m && rd_m != 0 && rd_m == rs1_e
  - else 01 if regwrite_w && rd_w != 0 && rd_w == rs1_e
  - else 00
  - M has priority over W. fwd_b_e is identical using rs2_e.
- Load-use detect: lu = load_e && rd_e != 0 && (rd_e == rs1_d || (use_rs2_d && rd_e == rs2_d)).
- FSM states: RUN and LU_STALL, plus a counter cnt of width clog2(LU_BUBBLES+1).
  - RUN, lu = 1: pc_en = fd_en = 0, flush_e = 1 (bubble 1). If LU_BUBBLES > 1, go to LU_STALL with cnt = LU_BUBBLES-1.
  - LU_STALL: pc_en = fd_en = 0, flush_e = 1, cnt decrements each cycle. When cnt reaches 1, the next state is RUN. Total bubbles = LU_BUBBLES exactly; lu is ignored while in LU_STALL.
- Branch flush: pcsrc_e = 1 gives flush_d = 1 and flush_e = 1, with pc_en = fd_en = 1 (PC loads the target).
  - Flush overrides a simultaneous lu or LU_STALL: stall cancelled, next state RUN, cnt = 0.
- Freeze: mem_busy = 1 gives pc_en = fd_en = de_en = em_en = 0 and flush_d = flush_e = 0.
  - State and cnt hold; a pending pcsrc_e is applied on the first cycle after mem_busy falls.
- Priority: reset > mem_busy > pcsrc_e > load-use.
- Default when no hazard: all enables 1, flushes 0.
- All outputs are combinational from inputs and the registered state. Zero-cycle latency from a hazard input to its control output.

Optional Feature:
HAZARD_PERF_EN
- Defined:
  - perf_stall increments once per bubble cycle (RUN-with-lu or LU_STALL, mem_busy = 0, pcsrc_e = 0).
  - perf_flush increments once per flush cycle.
  - perf_freeze increments once per mem_busy cycle.
  - Counters wrap modulo 2^PERF_W and clear on reset.
- Undefined: the three ports are present, driven constant 0, and no counter flops are built.

Test Plan:
- Load x5 in E, D reads rs1 = x5, LU_BUBBLES = 1 -> one cycle of pc_en = 0, fd_en = 0, flush_e = 1, then RUN with fwd_a_e = 01 the next cycle.
- LU_BUBBLES = 3, load x7 in E, D reads rs2 = x7 with use_rs2_d = 1 -> exactly 3 stall cycles. With use_rs2_d = 0 -> no stall.
- Load x0 in E, D reads rs1 = x0 -> no stall. regwrite_m = 1 with rd_m = 0 -> fwd = 00.
- rd_m = rd_w = rs1_e = x3, both regwrite set -> fwd_a_e = 10. With regwrite_m = 0 -> 01.
- lu and pcsrc_e in the same cycle -> flush_d = flush_e = 1, pc_en = 1, no stall in the following cycles.
- mem_busy high for 4 cycles during LU_STALL (cnt = 2) -> all enables 0 for 4 cycles, cnt still 2 afterwards. With HAZARD_PERF_EN, perf_freeze = 4.
- rst_n asserted mid-LU_STALL -> outputs go to reset values immediately (asynchronously); after release, state is RUN.

Source files
------------

// File: rtl/hazard_unit_p.sv
// Hazard controller for the 5-stage RV32I pipeline: EX forwarding, load-use bubbles, branch flush, memory-busy freeze.
// Optional performance counters are enabled by defining HAZARD_PERF_EN.
module hazard_unit_p #(
    parameter int ADDR_W     = 5,
    parameter int LU_BUBBLES = 1,
    parameter int PERF_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs1_d,
    input  logic [ADDR_W-1:0] rs2_d,
    input  logic              use_rs2_d,
    input  logic [ADDR_W-1:0] rs1_e,
    input  logic [ADDR_W-1:0] rs2_e,
    input  logic [ADDR_W-1:0] rd_e,
    input  logic              load_e,
    input  logic              pcsrc_e,
    input  logic [ADDR_W-1:0] rd_m,
    input  logic              regwrite_m,
    input  logic [ADDR_W-1:0] rd_w,
    input  logic              regwrite_w,
    input  logic              mem_busy,
    output logic              pc_en,
    output logic              fd_en,
    output logic              de_en,
    output logic              em_en,
    output logic              flush_d,
    output logic              flush_e,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic [PERF_W-1:0] perf_stall,
    output logic [PERF_W-1:0] perf_flush,
    output logic [PERF_W-1:0] perf_freeze
);

    localparam int CNT_W = $clog2(LU_BUBBLES + 1);

    typedef enum logic {RUN, LU_STALL} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               lu;

    // x0 is hardwired to zero, so a match on address 0 is never a hazard
    function automatic logic hit(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [ADDR_W-1:0] rs);
        if (regwrite_m && hit(rd_m, rs))
            return 2'b10;
        else if (regwrite_w && hit(rd_w, rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign lu = load_e && (hit(rd_e, rs1_d) || (use_rs2_d && hit(rd_e, rs2_d)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pc_en    = 1'b1;
        fd_en    = 1'b1;
        de_en    = 1'b1;
        em_en    = 1'b1;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        fwd_a_e  = fwd_sel(rs1_e);
        fwd_b_e  = fwd_sel(rs2_e);
        if (!rst_n) begin
            pc_en   = 1'b0;
            fd_en   = 1'b0;
            de_en   = 1'b0;
            em_en   = 1'b0;
            flush_d = 1'b1;
            flush_e = 1'b1;
            fwd_a_e = 2'b00;
            fwd_b_e = 2'b00;
        end else if (mem_busy) begin
            // a pending pcsrc_e stays asserted in the frozen E stage and is taken once the freeze lifts
            pc_en = 1'b0;
            fd_en = 1'b0;
            de_en = 1'b0;
            em_en = 1'b0;
        end else if (pcsrc_e) begin
            flush_d  = 1'b1;
            flush_e  = 1'b1;
            state_nx = RUN;
            cnt_nx   = '0;
        end else if (state == LU_STALL) begin
            pc_en   = 1'b0;
            fd_en   = 1'b0;
            flush_e = 1'b1;
            cnt_nx  = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1))
                state_nx = RUN;
        end else if (lu) begin
            pc_en   = 1'b0;
            fd_en   = 1'b0;
            flush_e = 1'b1;
            if (LU_BUBBLES > 1) begin
                state_nx = LU_STALL;
                cnt_nx   = CNT_W'(LU_BUBBLES - 1);
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_q, flush_q, freeze_q;
    logic              bubble_cyc, flush_cyc;

    assign bubble_cyc = !mem_busy && !pcsrc_e && ((state == LU_STALL) || lu);
    assign flush_cyc  = !mem_busy && pcsrc_e;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q  <= '0;
            flush_q  <= '0;
            freeze_q <= '0;
        end else begin
            if (bubble_cyc) stall_q  <= stall_q + PERF_W'(1);
            if (flush_cyc)  flush_q  <= flush_q + PERF_W'(1);
            if (mem_busy)   freeze_q <= freeze_q + PERF_W'(1);
        end
    end

    assign perf_stall  = stall_q;
    assign perf_flush  = flush_q;
    assign perf_freeze = freeze_q;
`else
    assign perf_stall  = '0;
    assign perf_flush  = '0;
    assign perf_freeze = '0;
`endif

endmodule

// File: tb/tb_hazard_unit_p.sv
// Bench for hazard_unit_p: two instances (LU_BUBBLES = 1 and 3) share stimulus and are checked against a bubble-budget model.
// Perf-counter expectations follow HAZARD_PERF_EN when the bench is built with it.
module tb_hazard_unit_p;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       use_rs2_d, load_e, pcsrc_e, regwrite_m, regwrite_w, mem_busy;

    logic [1:0]  pc_en_v, fd_en_v, de_en_v, em_en_v, flush_d_v, flush_e_v;
    logic [1:0]  fa_v [2];
    logic [1:0]  fb_v [2];
    logic [31:0] ps_v [2];
    logic [31:0] pf_v [2];
    logic [31:0] pz_v [2];

    int unsigned errors = 0;
    int unsigned checks = 0;

    // model: bubbles still owed per instance, plus event counts
    int          lu_cfg [2] = '{1, 3};
    int          rem    [2];
    logic [31:0] m_ps [2];
    logic [31:0] m_pf [2];
    logic [31:0] m_pz [2];

    always #5 clk = ~clk;

    hazard_unit_p #(.ADDR_W(5), .LU_BUBBLES(1), .PERF_W(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs2_d(use_rs2_d),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .load_e(load_e), .pcsrc_e(pcsrc_e),
        .rd_m(rd_m), .regwrite_m(regwrite_m), .rd_w(rd_w), .regwrite_w(regwrite_w),
        .mem_busy(mem_busy), .pc_en(pc_en_v[0]), .fd_en(fd_en_v[0]), .de_en(de_en_v[0]),
        .em_en(em_en_v[0]), .flush_d(flush_d_v[0]), .flush_e(flush_e_v[0]),
        .fwd_a_e(fa_v[0]), .fwd_b_e(fb_v[0]), .perf_stall(ps_v[0]), .perf_flush(pf_v[0]),
        .perf_freeze(pz_v[0])
    );

    hazard_unit_p #(.ADDR_W(5), .LU_BUBBLES(3), .PERF_W(32)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs2_d(use_rs2_d),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .load_e(load_e), .pcsrc_e(pcsrc_e),
        .rd_m(rd_m), .regwrite_m(regwrite_m), .rd_w(rd_w), .regwrite_w(regwrite_w),
        .mem_busy(mem_busy), .pc_en(pc_en_v[1]), .fd_en(fd_en_v[1]), .de_en(de_en_v[1]),
        .em_en(em_en_v[1]), .flush_d(flush_d_v[1]), .flush_e(flush_e_v[1]),
        .fwd_a_e(fa_v[1]), .fwd_b_e(fb_v[1]), .perf_stall(ps_v[1]), .perf_flush(pf_v[1]),
        .perf_freeze(pz_v[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (rs == 0) return 2'b00;
        if (regwrite_m && rd_m == rs) return 2'b10;
        if (regwrite_w && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic m_lu();
        if (!load_e || rd_e == 0) return 1'b0;
        return (rd_e == rs1_d) || (use_rs2_d && rd_e == rs2_d);
    endfunction

    task automatic clear_in();
        rs1_d = 0; rs2_d = 0; use_rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0;
        load_e = 0; pcsrc_e = 0; rd_m = 0; regwrite_m = 0; rd_w = 0; regwrite_w = 0;
        mem_busy = 0;
    endtask

    // compare every output of both instances at the falling edge
    task automatic eval();
        logic [5:0] ctl;
        logic [1:0] fa, fb;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            fa = m_fwd(rs1_e);
            fb = m_fwd(rs2_e);
            if (!rst_n) begin
                ctl = 6'b0000_11; fa = 0; fb = 0;
            end else if (mem_busy)                   ctl = 6'b0000_00;
            else if (pcsrc_e)                        ctl = 6'b1111_11;
            else if (rem[k] > 0 || m_lu())           ctl = 6'b0011_01;
            else                                     ctl = 6'b1111_00;
            // ctl = {pc_en, fd_en, de_en, em_en, flush_d, flush_e}
            chk($sformatf("pc_en[%0d]", k),   32'(pc_en_v[k]),   32'(ctl[5]));
            chk($sformatf("fd_en[%0d]", k),   32'(fd_en_v[k]),   32'(ctl[4]));
            chk($sformatf("de_en[%0d]", k),   32'(de_en_v[k]),   32'(ctl[3]));
            chk($sformatf("em_en[%0d]", k),   32'(em_en_v[k]),   32'(ctl[2]));
            chk($sformatf("flush_d[%0d]", k), 32'(flush_d_v[k]), 32'(ctl[1]));
            chk($sformatf("flush_e[%0d]", k), 32'(flush_e_v[k]), 32'(ctl[0]));
            chk($sformatf("fwd_a[%0d]", k),   32'(fa_v[k]),      32'(fa));
            chk($sformatf("fwd_b[%0d]", k),   32'(fb_v[k]),      32'(fb));
`ifdef HAZARD_PERF_EN
            chk($sformatf("perf_stall[%0d]", k),  ps_v[k], m_ps[k]);
            chk($sformatf("perf_flush[%0d]", k),  pf_v[k], m_pf[k]);
            chk($sformatf("perf_freeze[%0d]", k), pz_v[k], m_pz[k]);
`else
            chk($sformatf("perf_stall[%0d]", k),  ps_v[k], 32'd0);
            chk($sformatf("perf_flush[%0d]", k),  pf_v[k], 32'd0);
            chk($sformatf("perf_freeze[%0d]", k), pz_v[k], 32'd0);
`endif
        end
    endtask

    task automatic adv();
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                rem[k] = 0; m_ps[k] = 0; m_pf[k] = 0; m_pz[k] = 0;
            end else if (mem_busy) begin
                m_pz[k]++;
            end else if (pcsrc_e) begin
                m_pf[k]++; rem[k] = 0;
            end else if (rem[k] > 0) begin
                m_ps[k]++; rem[k]--;
            end else if (m_lu()) begin
                m_ps[k]++; rem[k] = lu_cfg[k] - 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    int n1, n3, nfz;
    logic [31:0] pz_before;

    task automatic step_count();
        eval();
        if (!pc_en_v[0]) n1++;
        if (!pc_en_v[1]) n3++;
        if (!pc_en_v[1] && !de_en_v[1] && !em_en_v[1] && !flush_e_v[1]) nfz++;
        adv();
    endtask

    initial begin
        rst_n = 0;
        clear_in();
        for (int k = 0; k < 2; k++) begin
            rem[k] = 0; m_ps[k] = 0; m_pf[k] = 0; m_pz[k] = 0;
        end
        eval();
        chk("rst_pc_en", 32'(pc_en_v[1]), 32'd0);
        chk("rst_flush_d", 32'(flush_d_v[0]), 32'd1);
        adv();
        rst_n = 1;
        eval(); adv();

        // load x5 in E, D reads x5: one bubble (LU=1), then forwarding from W
        n1 = 0; n3 = 0;
        load_e = 1; rd_e = 5; rs1_d = 5;
        step_count();
        chk("lu1_flush_e", 32'(flush_e_v[0]), 32'd1);
        clear_in();
        rs1_e = 5; rd_w = 5; regwrite_w = 1;
        eval();
        chk("lu1_run_pc_en", 32'(pc_en_v[0]), 32'd1);
        chk("lu1_fwd_a", 32'(fa_v[0]), 32'd1);
        adv();
        clear_in();
        for (int i = 0; i < 3; i++) step_count();

        // load x7, D reads rs2 = x7: exactly LU_BUBBLES stall cycles
        n1 = 0; n3 = 0;
        load_e = 1; rd_e = 7; rs2_d = 7; rs1_d = 1; use_rs2_d = 1;
        step_count();
        clear_in();
        for (int i = 0; i < 5; i++) step_count();
        chk("lu_rs2_bubbles1", 32'(n1), 32'd1);
        chk("lu_rs2_bubbles3", 32'(n3), 32'd3);

        // same registers but rs2 not used: no stall
        n1 = 0; n3 = 0;
        load_e = 1; rd_e = 7; rs2_d = 7; rs1_d = 1; use_rs2_d = 0;
        step_count();
        clear_in();
        step_count();
        chk("no_rs2_stall", 32'(n3), 32'd0);

        // x0 never hazards
        n3 = 0;
        load_e = 1; rd_e = 0; rs1_d = 0; regwrite_m = 1; rd_m = 0; rs1_e = 0;
        eval();
        chk("x0_fwd_a", 32'(fa_v[1]), 32'd0);
        if (!pc_en_v[1]) n3++;
        adv();
        chk("x0_no_stall", 32'(n3), 32'd0);

        // M has priority over W
        clear_in();
        rd_m = 3; rd_w = 3; rs1_e = 3; rs2_e = 3; regwrite_m = 1; regwrite_w = 1;
        eval();
        chk("fwd_m_prio", 32'(fa_v[0]), 32'd2);
        adv();
        regwrite_m = 0;
        eval();
        chk("fwd_w_only", 32'(fb_v[1]), 32'd1);
        adv();

        // load-use and branch in the same cycle: flush wins, no stall after
        clear_in();
        n1 = 0; n3 = 0;
        load_e = 1; rd_e = 4; rs1_d = 4; pcsrc_e = 1;
        eval();
        chk("lu_br_flush_d", 32'(flush_d_v[1]), 32'd1);
        chk("lu_br_pc_en", 32'(pc_en_v[1]), 32'd1);
        adv();
        clear_in();
        for (int i = 0; i < 4; i++) step_count();
        chk("lu_br_no_stall", 32'(n3), 32'd0);

        // freeze for 4 cycles in the middle of a 3-bubble stall
        n3 = 0; nfz = 0;
        load_e = 1; rd_e = 6; rs1_d = 6;
        step_count();
        clear_in();
        pz_before = pz_v[1];
        mem_busy = 1;
        for (int i = 0; i < 4; i++) step_count();
        mem_busy = 0;
`ifdef HAZARD_PERF_EN
        chk("perf_freeze_delta", pz_v[1] - pz_before, 32'd4);
`endif
        for (int i = 0; i < 4; i++) step_count();
        chk("freeze_cycles", 32'(nfz), 32'd4);
        chk("freeze_bubbles", 32'(n3 - nfz), 32'd3);

        // asynchronous reset mid-stall
        load_e = 1; rd_e = 2; rs1_d = 2; regwrite_m = 1; rd_m = 3; rs1_e = 3;
        eval(); adv();
        clear_in();
        regwrite_m = 1; rd_m = 3; rs1_e = 3;
        #2;
        rst_n = 0;
        #1;
        chk("arst_pc_en", 32'(pc_en_v[1]), 32'd0);
        chk("arst_em_en", 32'(em_en_v[1]), 32'd0);
        chk("arst_flush_e", 32'(flush_e_v[1]), 32'd1);
        chk("arst_fwd_a", 32'(fa_v[1]), 32'd0);
        eval(); adv();
        rst_n = 1;
        eval();
        chk("after_rst_run", 32'(pc_en_v[1]), 32'd1);
        adv();

        // randomized traffic over a small register window to provoke collisions
        for (int i = 0; i < 400; i++) begin
            rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
            rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
            rd_e = 5'($urandom_range(0, 3)); rd_m = 5'($urandom_range(0, 3));
            rd_w = 5'($urandom_range(0, 3));
            use_rs2_d = 1'($urandom_range(0, 1));
            load_e = ($urandom_range(0, 2) == 0);
            pcsrc_e = ($urandom_range(0, 7) == 0);
            mem_busy = ($urandom_range(0, 5) == 0);
            regwrite_m = 1'($urandom_range(0, 1));
            regwrite_w = 1'($urandom_range(0, 1));
            eval(); adv();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
